// File: rtl/rat_flags.sv
// ---------------------------------------------------------------------------
// rat_flags
//   Processor status flag file: carry (C), zero (Z), interrupt enable (I),
//   a one-deep C/Z shadow register, and the external interrupt request path
//   (synchronizer, edge detector, pending bit).
//
// Parameters
//   SYNC_STAGES  number of synchronizer flops on INTR (legal 2..4)
//
// Ports
//   CLK          rising-edge clock for all state
//   RST          asynchronous active-high reset, clears every flop
//   C_IN, Z_IN   carry / zero results from the ALU
//   FLG_C_LD     load C from the selected source
//   FLG_Z_LD     load Z from the selected source
//   FLG_C_SET    force C to 1
//   FLG_C_CLR    force C to 0 (highest priority on C)
//   FLG_LD_SEL   load source: 0 = ALU, 1 = shadow register
//   FLG_SHAD_LD  copy current C/Z into the shadow register
//   I_SET        enable interrupts
//   I_CLR        disable interrupts
//   INTR         external interrupt request, asynchronous to CLK
//   INT_ACK      control-unit acknowledge of interrupt entry
//   C_FLAG, Z_FLAG, I_FLAG  registered flags
//   SHAD_C, SHAD_Z          registered shadow flags
//   INT_PEND     pending request qualified by I_FLAG (combinational)
// ---------------------------------------------------------------------------
module rat_flags #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic C_IN,
  input  logic Z_IN,
  input  logic FLG_C_LD,
  input  logic FLG_Z_LD,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic FLG_LD_SEL,
  input  logic FLG_SHAD_LD,
  input  logic I_SET,
  input  logic I_CLR,
  input  logic INTR,
  input  logic INT_ACK,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic I_FLAG,
  output logic SHAD_C,
  output logic SHAD_Z,
  output logic INT_PEND
);

  // Flag state
  logic c_q, c_d;
  logic z_q, z_d;
  logic i_q, i_d;
  logic shad_c_q, shad_c_d;
  logic shad_z_q, shad_z_d;

  // Interrupt request path
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   pend_q, pend_d;

  logic src_c;
  logic src_z;
  logic intr_sync;
  logic intr_rise;

  // ---------------------------------------------------------------------
  // Load source selection. Shadow-sourced loads read the registered
  // shadow, so a simultaneous FLG_SHAD_LD yields a clean swap: both sides
  // see only pre-edge values.
  // ---------------------------------------------------------------------
  always_comb begin
    src_c = C_IN;
    src_z = Z_IN;
    if (FLG_LD_SEL) begin
      src_c = shad_c_q;
      src_z = shad_z_q;
    end
  end

  // Carry: clear beats set beats load beats hold.
  always_comb begin
    c_d = c_q;
    if (FLG_C_CLR) begin
      c_d = 1'b0;
    end else if (FLG_C_SET) begin
      c_d = 1'b1;
    end else if (FLG_C_LD) begin
      c_d = src_c;
    end
  end

  // Zero: load or hold.
  always_comb begin
    z_d = z_q;
    if (FLG_Z_LD) begin
      z_d = src_z;
    end
  end

  // Shadow captures the pre-edge flag values.
  always_comb begin
    shad_c_d = shad_c_q;
    shad_z_d = shad_z_q;
    if (FLG_SHAD_LD) begin
      shad_c_d = c_q;
      shad_z_d = z_q;
    end
  end

  // Interrupt enable: acknowledge beats clear beats set beats hold.
  always_comb begin
    i_d = i_q;
    if (INT_ACK) begin
      i_d = 1'b0;
    end else if (I_CLR) begin
      i_d = 1'b0;
    end else if (I_SET) begin
      i_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Interrupt request path. INTR shifts into sync_q[0]; the last stage is
  // the synchronized level, and hist_q holds it for one more cycle so a
  // held level produces exactly one rising-edge pulse.
  // ---------------------------------------------------------------------
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], INTR};
  end

  always_comb begin
    intr_sync = sync_q[SYNC_STAGES-1];
    hist_d    = intr_sync;
    intr_rise = intr_sync & ~hist_q;
  end

  // A new edge wins over an acknowledge in the same cycle so the fresh
  // request is not lost. Edges latch regardless of I_FLAG.
  always_comb begin
    pend_d = pend_q;
    if (intr_rise) begin
      pend_d = 1'b1;
    end else if (INT_ACK) begin
      pend_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      i_q      <= 1'b0;
      shad_c_q <= 1'b0;
      shad_z_q <= 1'b0;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      c_q      <= c_d;
      z_q      <= z_d;
      i_q      <= i_d;
      shad_c_q <= shad_c_d;
      shad_z_q <= shad_z_d;
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      pend_q   <= pend_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    C_FLAG   = c_q;
    Z_FLAG   = z_q;
    I_FLAG   = i_q;
    SHAD_C   = shad_c_q;
    SHAD_Z   = shad_z_q;
    INT_PEND = pend_q & i_q;
  end

endmodule

// File: tb/tb_rat_flags.sv
module tb_rat_flags;

  logic CLK = 1'b0;
  logic RST;
  logic C_IN, Z_IN;
  logic FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR, FLG_LD_SEL, FLG_SHAD_LD;
  logic I_SET, I_CLR, INTR, INT_ACK;
  logic C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_PEND;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  rat_flags #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST),
    .C_IN(C_IN), .Z_IN(Z_IN),
    .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD),
    .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR),
    .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
    .I_SET(I_SET), .I_CLR(I_CLR), .INTR(INTR), .INT_ACK(INT_ACK),
    .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
    .SHAD_C(SHAD_C), .SHAD_Z(SHAD_Z), .INT_PEND(INT_PEND)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_ctl();
    FLG_C_LD = 0; FLG_Z_LD = 0; FLG_C_SET = 0; FLG_C_CLR = 0;
    FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
  endtask

  task automatic chk_all(input string tag, input logic c, input logic z,
                         input logic i, input logic sc, input logic sz,
                         input logic p);
    chk({tag, ".C"}, C_FLAG, c);
    chk({tag, ".Z"}, Z_FLAG, z);
    chk({tag, ".I"}, I_FLAG, i);
    chk({tag, ".SC"}, SHAD_C, sc);
    chk({tag, ".SZ"}, SHAD_Z, sz);
    chk({tag, ".PEND"}, INT_PEND, p);
  endtask

  initial begin
    RST = 1; C_IN = 0; Z_IN = 0; INTR = 0;
    idle_ctl();
    #7;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 0;

    // Load C and Z from the ALU, then hold
    C_IN = 1; Z_IN = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
    step();
    idle_ctl(); C_IN = 0; Z_IN = 0;
    chk("alu_ld.C", C_FLAG, 1); chk("alu_ld.Z", Z_FLAG, 1);
    step();
    chk("alu_hold.C", C_FLAG, 1); chk("alu_hold.Z", Z_FLAG, 1);

    // Carry priority
    FLG_C_CLR = 1; FLG_C_SET = 1; FLG_C_LD = 1; C_IN = 1;
    step();
    idle_ctl(); C_IN = 0;
    chk("prio_clr.C", C_FLAG, 0);
    FLG_C_SET = 1;
    step();
    idle_ctl();
    chk("prio_set.C", C_FLAG, 1);

    // Build C=1 Z=0 with shadow 0/1
    FLG_C_LD = 1; C_IN = 0;              // C=0, Z stays 1
    step();
    idle_ctl();
    chk("prep1.C", C_FLAG, 0); chk("prep1.Z", Z_FLAG, 1);
    FLG_SHAD_LD = 1;                     // shadow <= 0/1
    step();
    idle_ctl();
    chk("prep2.SC", SHAD_C, 0); chk("prep2.SZ", SHAD_Z, 1);
    FLG_C_SET = 1; FLG_Z_LD = 1; Z_IN = 0; // C=1, Z=0
    step();
    idle_ctl();
    chk_all("prep3", 1, 0, 0, 0, 1, 0);

    // Swap flags and shadow
    FLG_SHAD_LD = 1; FLG_LD_SEL = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
    step();
    idle_ctl();
    chk_all("swap", 0, 1, 0, 1, 0, 0);

    // Interrupt latency with I_FLAG=1
    I_SET = 1;
    step();
    idle_ctl();
    chk("ien.I", I_FLAG, 1);
    INTR = 1;                            // before edge 0
    step();                              // edge 0
    chk("lat.e0", INT_PEND, 0);
    step();                              // edge 1
    chk("lat.e1", INT_PEND, 0);
    step();                              // edge 2
    chk("lat.e2", INT_PEND, 1);
    step();
    chk("lat.e3", INT_PEND, 1);
    INT_ACK = 1;
    step();
    idle_ctl();
    chk("ack.PEND", INT_PEND, 0); chk("ack.I", I_FLAG, 0);
    I_SET = 1;                           // level still high: no re-arm
    step();
    idle_ctl();
    chk("held.I", I_FLAG, 1);
    step(); step();
    chk("held.PEND", INT_PEND, 0);

    // Masked request, then enable
    I_CLR = 1; INTR = 0;
    step();
    idle_ctl();
    chk("mask.I", I_FLAG, 0);
    step(); step(); step();
    INTR = 1;
    step(); step(); step();
    INTR = 0;
    step(); step();
    chk("masked.PEND", INT_PEND, 0);
    I_SET = 1;
    step();
    idle_ctl();
    chk("unmask.PEND", INT_PEND, 1);

    // Edge coincident with INT_ACK keeps the request pending
    INT_ACK = 1;                         // clear old request first
    step();
    idle_ctl();
    I_SET = 1;
    step();
    idle_ctl();
    chk("clr_old.PEND", INT_PEND, 0);
    INTR = 1;
    step();                              // edge 0
    step();                              // edge 1
    INT_ACK = 1;                         // lands on edge 2 with the new edge
    step();
    idle_ctl();
    chk("coinc.I", I_FLAG, 0);
    I_SET = 1;
    step();
    idle_ctl();
    chk("coinc.PEND", INT_PEND, 1);

    // Async reset with all flags set and a request pending
    FLG_C_SET = 1; FLG_Z_LD = 1; Z_IN = 1; FLG_LD_SEL = 0;
    step();
    idle_ctl();
    FLG_SHAD_LD = 1;
    step();
    idle_ctl();
    chk_all("allset", 1, 1, 1, 1, 1, 1);
    #2 RST = 1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    FLG_C_SET = 1; I_SET = 1; FLG_SHAD_LD = 1; FLG_Z_LD = 1;
    step();
    chk_all("rst_ignore", 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    idle_ctl();
    RST = 0;
    I_SET = 1;                           // INTR still high
    step();                              // edge A
    idle_ctl();
    chk("rearm.I", I_FLAG, 1);
    chk("rearm.eA", INT_PEND, 0);
    step();
    chk("rearm.eB", INT_PEND, 0);
    step();
    chk("rearm.eC", INT_PEND, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rat_flags.md
RAT_FLAGS -- requirements
Module: rat_flags

Interface
- REQ-001: The block SHALL have one parameter, SYNC_STAGES, default 2, giving the number of synchronizer flops on INTR (legal values 2..4).
- REQ-002: CLK  input  1  sole clock; all state SHALL update on the rising edge only.
- REQ-003: RST  input  1  reset, asynchronous and active-high.
- REQ-004: C_IN  input  1  carry result from the ALU.
- REQ-005: Z_IN  input  1  zero result from the ALU.
- REQ-006: FLG_C_LD  input  1  load C from the selected source.
- REQ-007: FLG_Z_LD  input  1  load Z from the selected source.
- REQ-008: FLG_C_SET  input  1  force C to 1.
- REQ-009: FLG_C_CLR  input  1  force C to 0.
- REQ-010: FLG_LD_SEL  input  1  load source select: 0 = ALU (C_IN/Z_IN), 1 = shadow (SHAD_C/SHAD_Z).
- REQ-011: FLG_SHAD_LD  input  1  copy the current C_FLAG/Z_FLAG into the shadow register.
- REQ-012: I_SET  input  1  enable interrupts.
- REQ-013: I_CLR  input  1  disable interrupts.
- REQ-014: INTR  input  1  external interrupt request, asynchronous to CLK.
- REQ-015: INT_ACK  input  1  control-unit acknowledge of interrupt entry.
- REQ-016: C_FLAG, Z_FLAG, I_FLAG  output  1 each  registered carry, zero and interrupt-enable flags.
- REQ-017: SHAD_C, SHAD_Z  output  1 each  registered shadow flags.
- REQ-018: INT_PEND  output  1  combinational AND of the registered pending bit and I_FLAG.

Function
- REQ-019: C next-state priority SHALL be: FLG_C_CLR -> 0, else FLG_C_SET -> 1, else FLG_C_LD -> the selected source, else hold.
- REQ-020: Z next-state SHALL be: FLG_Z_LD -> the selected source, else hold.
- REQ-021: FLG_SHAD_LD SHALL capture the pre-edge C_FLAG/Z_FLAG values.
- REQ-022: If FLG_SHAD_LD and a shadow-sourced load occur in the same cycle, the flags and shadow SHALL swap, using only pre-edge values on both sides.
- REQ-023: I_FLAG next-state priority SHALL be: INT_ACK -> 0, else I_CLR -> 0, else I_SET -> 1, else hold.
- REQ-024: INTR SHALL pass through a SYNC_STAGES-flop synchronizer, followed by one history flop for edge detection.
- REQ-025: A synchronized rising edge SHALL set the pending bit on the next edge; INTR high before edge n SHALL set pending at edge n+SYNC_STAGES.
- REQ-026: A level held high SHALL set pending once only; re-arming SHALL require INTR to go low and then high again.
- REQ-027: INT_ACK SHALL clear the pending bit.
- REQ-028: If a detected edge and INT_ACK coincide, the pending bit SHALL remain set (the new request is not lost).
- REQ-029: While I_FLAG=0, the pending bit SHALL still latch edges, but INT_PEND SHALL be 0.
- REQ-030: INT_PEND SHALL assert combinationally when I_SET takes effect, if a request is already pending.
- REQ-031: Flag loads SHALL take effect one edge after the control inputs are sampled, with no added latency.

Reset
- REQ-032: RST=1 SHALL immediately, independent of CLK, force C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, all synchronizer/history flops and the pending bit to 0, so INT_PEND=0.
- REQ-033: A reset asserted mid-interrupt-request SHALL discard that request.
- REQ-034: After RST deasserts, a still-high INTR SHALL be detected as a new edge.
- REQ-035: All control inputs SHALL be ignored while RST=1.

Verification
- REQ-036: Load from ALU: C_IN=1, Z_IN=1, FLG_LD_SEL=0, FLG_C_LD=FLG_Z_LD=1 for one cycle -> C_FLAG=1 and Z_FLAG=1 after that edge, held afterwards.
- REQ-037: Priority: FLG_C_CLR=FLG_C_SET=FLG_C_LD=1 with C_IN=1 -> C_FLAG=0; then FLG_C_SET=1 alone -> C_FLAG=1.
- REQ-038: Shadow swap: C=1, Z=0, SHAD=0/1, then FLG_SHAD_LD=1, FLG_LD_SEL=1, both LDs=1 -> C=0, Z=1, SHAD_C=1, SHAD_Z=0.
- REQ-039: Interrupt latency: I_FLAG=1, SYNC_STAGES=2, INTR rises before edge 0 and is held -> INT_PEND=1 after edge 2, exactly once; INT_ACK pulse -> INT_PEND=0 and I_FLAG=0 next edge.
- REQ-040: Masked then enabled: I_FLAG=0, INTR pulse of 3 cycles -> INT_PEND=0; I_SET -> INT_PEND=1 after that edge.
- REQ-041: Async reset: RST pulsed between clock edges with all flags=1 and a pending request -> all outputs 0 before the next CLK edge.
